// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read side of an async FIFO with write-pointer sync, Gray read pointer and a prefetched valid/ready output stage
module fifo_read_ctrl #(
  parameter int dataWidth         = 8,
  parameter int addrWidth         = 4,
  parameter int almostEmptyThresh = 2,
  parameter int syncStages        = 2
) (
  input  logic                 readClkIn,
  input  logic                 readResetNIn,
  input  logic [addrWidth:0]   writePtrGrayIn,
  input  logic [dataWidth-1:0] memDataIn,
  output logic [addrWidth-1:0] readAddrOut,
  output logic [addrWidth:0]   readPtrGrayOut,
  output logic [dataWidth-1:0] dataOut,
  output logic                 dataValidOut,
  input  logic                 dataReadyIn,
  output logic                 fifoEmptyOut,
  output logic                 almostEmptyOut,
  output logic [addrWidth:0]   fillLevelOut
);
  localparam int PW = addrWidth + 1;

  logic [syncStages-1:0][PW-1:0] r_sync;
  logic [PW-1:0]                 r_ptr_bin, r_ptr_gray;
  logic [dataWidth-1:0]          r_data;
  logic                          r_valid;
  logic [PW-1:0]                 w_wgray_sync, w_wbin_sync, w_ptr_bin_nxt;
  logic                          w_mem_empty, w_pop;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int i = 1; i < PW; i++) b ^= g >> i;
    return b;
  endfunction

  assign w_wgray_sync  = r_sync[syncStages-1];
  assign w_wbin_sync   = gray2bin(w_wgray_sync);
  assign w_ptr_bin_nxt = r_ptr_bin + PW'(1);
  // Empty is judged on the registered Gray pointers only, so it never glitches
  assign w_mem_empty   = (r_ptr_gray == w_wgray_sync);
  // Refill the output stage whenever it is free or being drained this cycle
  assign w_pop         = ~w_mem_empty & (~r_valid | dataReadyIn);

  assign readAddrOut    = r_ptr_bin[addrWidth-1:0];
  assign readPtrGrayOut = r_ptr_gray;
  assign dataOut        = r_data;
  assign dataValidOut   = r_valid;
  assign fillLevelOut   = w_wbin_sync - r_ptr_bin;
  assign fifoEmptyOut   = w_mem_empty & ~r_valid;
  assign almostEmptyOut = (fillLevelOut <= PW'(almostEmptyThresh));

  // Bring the write-domain Gray pointer across through a flop chain
  always_ff @(posedge readClkIn or negedge readResetNIn)
    if (!readResetNIn) r_sync <= '0;
    else               r_sync <= {r_sync[syncStages-2:0], writePtrGrayIn};

  // Read pointer and output stage advance together on a pop; dataOut is kept when drained
  always_ff @(posedge readClkIn or negedge readResetNIn)
    if (!readResetNIn) begin
      r_ptr_bin  <= '0;
      r_ptr_gray <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
    end else if (w_pop) begin
      r_ptr_bin  <= w_ptr_bin_nxt;
      r_ptr_gray <= w_ptr_bin_nxt ^ (w_ptr_bin_nxt >> 1);
      r_data     <= memDataIn;
      r_valid    <= 1'b1;
    end else if (r_valid && dataReadyIn) begin
      r_valid    <= 1'b0;
    end
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb_fifo_read_ctrl: vector table plus randomized run against a word-count model of the read controller
module tb_fifo_read_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] writePtrGrayIn = '0;
  logic [7:0] memDataIn;
  logic [3:0] readAddrOut;
  logic [4:0] readPtrGrayOut;
  logic [7:0] dataOut;
  logic       dataValidOut;
  logic       dataReadyIn = 1'b0;
  logic       fifoEmptyOut, almostEmptyOut;
  logic [4:0] fillLevelOut;

  logic [7:0] mem [16];
  assign memDataIn = mem[readAddrOut];

  fifo_read_ctrl dut (
    .readClkIn(clk), .readResetNIn(rst_n), .writePtrGrayIn(writePtrGrayIn),
    .memDataIn(memDataIn), .readAddrOut(readAddrOut), .readPtrGrayOut(readPtrGrayOut),
    .dataOut(dataOut), .dataValidOut(dataValidOut), .dataReadyIn(dataReadyIn),
    .fifoEmptyOut(fifoEmptyOut), .almostEmptyOut(almostEmptyOut), .fillLevelOut(fillLevelOut)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Model: words written (wp), words moved into the output stage (m_rp),
  // write count as seen after each synchroniser flop (m_s0, m_s1), output stage full (m_valid)
  int wp, m_rp, m_s0, m_s1, beats;
  bit m_valid;
  logic [7:0] q [$];

  typedef struct {
    logic rst_n; logic [4:0] wg; logic rdy;
    logic v; logic [7:0] d; logic [3:0] a; logic [4:0] g; logic e; logic ae; logic [4:0] f;
  } vec_t;
  vec_t tbl [11];

  function automatic logic [4:0] gray(input int b);
    logic [4:0] x;
    x = 5'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int f;
    f = (m_s1 - m_rp) & 31;
    chk("valid", dataValidOut, 32'(m_valid));
    chk("addr", readAddrOut, m_rp & 15);
    chk("rgray", readPtrGrayOut, gray(m_rp));
    chk("fill", fillLevelOut, f);
    chk("empty", fifoEmptyOut, 32'((f == 0) && !m_valid));
    chk("aempty", almostEmptyOut, 32'(f <= 2));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    dataReadyIn = 1'b0;
    writePtrGrayIn = '0;
    wp = 0; m_rp = 0; m_s0 = 0; m_s1 = 0; m_valid = 0; beats = 0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cycle(input bit rdy, input int nwr);
    bit pop;
    @(negedge clk);
    check_outputs();
    dataReadyIn = rdy;
    for (int k = 0; k < nwr && wp - m_rp < 16; k++) begin
      mem[wp % 16] = 8'($urandom);
      q.push_back(mem[wp % 16]);
      wp++;
    end
    writePtrGrayIn = gray(wp);
    if (m_valid && rdy) begin
      beats++;
      if (q.size() == 0) chk("data_underflow", 1, 0);
      else chk("data", dataOut, q.pop_front());
    end
    pop = ((m_s1 & 31) != (m_rp & 31)) && (!m_valid || rdy);
    m_s1 = m_s0;
    m_s0 = wp & 31;
    if (pop) begin m_valid = 1; m_rp++; end
    else if (m_valid && rdy) m_valid = 0;
  endtask

  task automatic run_random(input int n, input int rdy_pct, input int wr_pct);
    for (int i = 0; i < n; i++)
      cycle($urandom_range(99) < rdy_pct, ($urandom_range(99) < wr_pct) ? 1 : 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h5A;
    //              rst wg     rdy  v  d      a  g      e  ae f
    tbl[0]  = '{1'b0, 5'h03, 1'b0, 1'b0, 8'h00, 4'd0, 5'h00, 1'b1, 1'b1, 5'd0};
    tbl[1]  = '{1'b1, 5'h03, 1'b0, 1'b0, 8'h00, 4'd0, 5'h00, 1'b1, 1'b1, 5'd0};
    tbl[2]  = '{1'b1, 5'h03, 1'b0, 1'b0, 8'h00, 4'd0, 5'h00, 1'b0, 1'b1, 5'd2};
    tbl[3]  = '{1'b1, 5'h03, 1'b0, 1'b1, 8'hA5, 4'd1, 5'h01, 1'b0, 1'b1, 5'd1};
    tbl[4]  = '{1'b1, 5'h03, 1'b0, 1'b1, 8'hA5, 4'd1, 5'h01, 1'b0, 1'b1, 5'd1};
    tbl[5]  = '{1'b1, 5'h03, 1'b1, 1'b1, 8'h3C, 4'd2, 5'h03, 1'b0, 1'b1, 5'd0};
    tbl[6]  = '{1'b1, 5'h03, 1'b1, 1'b0, 8'h3C, 4'd2, 5'h03, 1'b1, 1'b1, 5'd0};
    tbl[7]  = '{1'b1, 5'h02, 1'b0, 1'b0, 8'h3C, 4'd2, 5'h03, 1'b1, 1'b1, 5'd0};
    tbl[8]  = '{1'b1, 5'h02, 1'b0, 1'b0, 8'h3C, 4'd2, 5'h03, 1'b0, 1'b1, 5'd1};
    tbl[9]  = '{1'b1, 5'h02, 1'b0, 1'b1, 8'h5A, 4'd3, 5'h02, 1'b0, 1'b1, 5'd0};
    tbl[10] = '{1'b1, 5'h02, 1'b1, 1'b0, 8'h5A, 4'd3, 5'h02, 1'b1, 1'b1, 5'd0};

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      rst_n = tbl[i].rst_n;
      writePtrGrayIn = tbl[i].wg;
      dataReadyIn = tbl[i].rdy;
      @(negedge clk);
      checks++;
      if ({dataValidOut, dataOut, readAddrOut, readPtrGrayOut, fifoEmptyOut, almostEmptyOut, fillLevelOut} !==
          {tbl[i].v, tbl[i].d, tbl[i].a, tbl[i].g, tbl[i].e, tbl[i].ae, tbl[i].f}) begin
        errors++;
        $display("FAIL vec%0d: got v=%b d=%h a=%0d g=%b e=%b ae=%b f=%0d expected v=%b d=%h a=%0d g=%b e=%b ae=%b f=%0d",
                 i, dataValidOut, dataOut, readAddrOut, readPtrGrayOut, fifoEmptyOut, almostEmptyOut, fillLevelOut,
                 tbl[i].v, tbl[i].d, tbl[i].a, tbl[i].g, tbl[i].e, tbl[i].ae, tbl[i].f);
      end
    end

    // Burst: sixteen words appear at once, drained at one per cycle
    do_reset();
    cycle(1'b1, 16);
    repeat (24) cycle(1'b1, 0);
    chk("burst_beats", beats, 16);

    // Alternating backpressure over eight queued words
    do_reset();
    cycle(1'b0, 8);
    for (int i = 0; i < 24; i++) cycle(i[0] == 1'b0, 0);
    chk("bp_beats", beats, 8);

    // Random traffic; pointers wrap many times and the memory fills up
    do_reset();
    run_random(400, 70, 60);
    run_random(300, 25, 90);
    run_random(300, 100, 40);
    run_random(100, 100, 0);

    // Reset while a word is held: clears without a clock edge
    do_reset();
    cycle(1'b0, 3);
    repeat (4) cycle(1'b0, 0);
    @(negedge clk);
    chk("t6_pre_valid", dataValidOut, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", dataValidOut, 0);
    chk("t6_addr", readAddrOut, 0);
    chk("t6_rgray", readPtrGrayOut, 0);
    chk("t6_fill", fillLevelOut, 0);
    chk("t6_empty", fifoEmptyOut, 1);
    do_reset();
    repeat (4) cycle(1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
